rr_arbiter_ctrl: RTL and testbench

Parameterised round-robin arbiter that shares one resource between N requesters using a registered req/gnt handshake.
- Grants are one-hot, registered, and follow the sampled request by exactly one cycle.
- The owner keeps the grant while it holds its request, up to a hold limit; at the limit it is pre-empted if others are waiting.
- Sits in front of any shared datapath port (bus, memory bank, FIFO write side), replacing fixed-priority 2-way arbitration.

---
 rtl/rr_arbiter_ctrl.sv | 146 ++++++++++++++
 tb/tb_rr_arbiter_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter_ctrl
//  Description : Round-robin arbiter with registered one-hot grant, per-owner
//                hold limit with pre-emption, and a last-owner pointer that
//                rotates priority across N requesters.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter_ctrl #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  parameter int IDXW     = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    gnt,
  output logic            gnt_vld,
  output logic [IDXW-1:0] gnt_idx,
  output logic            preempt
);

  // Hold counter runs 0..MAX_HOLD-1; at least one bit even when MAX_HOLD=1.
  localparam int              HCW       = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HCW-1:0]  HOLD_LAST = HCW'(MAX_HOLD - 1);
  localparam logic [IDXW-1:0] PTR_RESET = IDXW'(N - 1);

  // Arbiter state: the grant-valid flag is the state itself.
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } state_e;

  state_e          state_q,    state_d;
  logic [N-1:0]    gnt_q,      gnt_d;
  logic [IDXW-1:0] gnt_idx_q,  gnt_idx_d;
  logic [IDXW-1:0] ptr_q,      ptr_d;
  logic [HCW-1:0]  hold_cnt_q, hold_cnt_d;
  logic            preempt_q,  preempt_d;

  // Candidates exclude the current owner; in IDLE gnt_q is zero so nothing
  // is masked. ptr_q always equals the current owner while OWNED, so one
  // search starting after ptr_q serves IDLE, release and pre-emption alike.
  logic [N-1:0]    cand;
  logic            req_own;
  logic            others;
  logic            search_hit;
  logic [IDXW-1:0] search_idx;

  assign cand    = req & ~gnt_q;
  assign req_own = |(req & gnt_q);
  assign others  = |cand;

  // Circular priority search over the candidates, starting at ptr_q+1.
  always_comb begin
    search_hit = 1'b0;
    search_idx = '0;
    for (int k = 1; k <= N; k++) begin
      int j;
      j = int'(ptr_q) + k;
      if (j >= N) j = j - N;
      if (!search_hit && cand[j]) begin
        search_hit = 1'b1;
        search_idx = IDXW'(j);
      end
    end
  end

  // Next-state and next-output decision for the grant FSM.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    gnt_idx_d  = gnt_idx_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    preempt_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (search_hit) begin
          state_d            = ST_OWNED;
          gnt_d              = '0;
          gnt_d[search_idx]  = 1'b1;
          gnt_idx_d          = search_idx;
          ptr_d              = search_idx;
          hold_cnt_d         = '0;
        end
      end

      ST_OWNED: begin
        if (req_own && ((hold_cnt_q != HOLD_LAST) || !others)) begin
          // Owner keeps the resource; count saturates at the limit so a
          // lone requester never gets pre-empted by nobody.
          if (hold_cnt_q != HOLD_LAST) begin
            hold_cnt_d = hold_cnt_q + HCW'(1);
          end
        end else if (search_hit) begin
          // Handover: either the owner released, or its hold expired with
          // someone else waiting. Only the latter is flagged as pre-emption.
          gnt_d             = '0;
          gnt_d[search_idx] = 1'b1;
          gnt_idx_d         = search_idx;
          ptr_d             = search_idx;
          hold_cnt_d        = '0;
          preempt_d         = req_own;
        end else begin
          // Owner released and nobody else wants it; index keeps last owner.
          state_d    = ST_IDLE;
          gnt_d      = '0;
          hold_cnt_d = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      gnt_idx_q  <= '0;
      ptr_q      <= PTR_RESET;
      hold_cnt_q <= '0;
      preempt_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      gnt_idx_q  <= gnt_idx_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      preempt_q  <= preempt_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_vld = (state_q == ST_OWNED);
  assign gnt_idx = gnt_idx_q;
  assign preempt = preempt_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_arbiter_ctrl
//  Description : Self-checking bench for rr_arbiter_ctrl. Three instances
//                (MAX_HOLD 8, 4 and 1) share one request vector and are
//                compared every cycle against a behavioural model, plus
//                hand-computed literal expectations at key points.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req = 4'b0000;
  logic       chk_en = 1'b0;

  int n_vec = 0;
  int n_bad = 0;

  logic [3:0] dg [3];
  logic       dv [3];
  logic [1:0] di [3];
  logic       dp [3];

  always #5 clk = ~clk;

  rr_arbiter_ctrl #(.N(4), .MAX_HOLD(8)) u_dut_a (
    .clk(clk), .reset(reset), .req(req),
    .gnt(dg[0]), .gnt_vld(dv[0]), .gnt_idx(di[0]), .preempt(dp[0]));

  rr_arbiter_ctrl #(.N(4), .MAX_HOLD(4)) u_dut_b (
    .clk(clk), .reset(reset), .req(req),
    .gnt(dg[1]), .gnt_vld(dv[1]), .gnt_idx(di[1]), .preempt(dp[1]));

  rr_arbiter_ctrl #(.N(4), .MAX_HOLD(1)) u_dut_c (
    .clk(clk), .reset(reset), .req(req),
    .gnt(dg[2]), .gnt_vld(dv[2]), .gnt_idx(di[2]), .preempt(dp[2]));

  // ---------------- behavioural model ----------------
  // m_held counts how many cycles the current owner has had the grant.
  int   lim    [3] = '{8, 4, 1};
  logic m_vld  [3] = '{1'b0, 1'b0, 1'b0};
  int   m_own  [3] = '{0, 0, 0};
  int   m_ptr  [3] = '{3, 3, 3};
  int   m_held [3] = '{0, 0, 0};
  logic m_pre  [3] = '{1'b0, 1'b0, 1'b0};

  // First set bit of r visiting start+1, start+2, ... (mod 4); -1 if none.
  function automatic int find(input logic [3:0] r, input int start);
    for (int k = 1; k <= 4; k++) begin
      int j;
      j = (start + k) % 4;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    for (int u = 0; u < 3; u++) begin
      logic       v;
      logic       pr;
      int         o, p, h, w;
      logic [3:0] oth;
      v = m_vld[u]; o = m_own[u]; p = m_ptr[u]; h = m_held[u]; pr = 1'b0;
      if (reset) begin
        v = 1'b0; o = 0; p = 3; h = 0;
      end else if (v) begin
        oth = req & ~(4'b0001 << o);
        if (req[o] && (h < lim[u] || oth == 4'b0000)) begin
          if (h < lim[u]) h = h + 1;
        end else begin
          w = find(oth, o);
          if (w >= 0) begin
            pr = req[o]; o = w; p = w; h = 1;
          end else begin
            v = 1'b0; h = 0;
          end
        end
      end else begin
        w = find(req, p);
        if (w >= 0) begin
          v = 1'b1; o = w; p = w; h = 1;
        end
      end
      m_vld[u]  <= v;
      m_own[u]  <= o;
      m_ptr[u]  <= p;
      m_held[u] <= h;
      m_pre[u]  <= pr;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      for (int u = 0; u < 3; u++) begin
        logic [3:0] eg;
        eg = m_vld[u] ? (4'b0001 << m_own[u]) : 4'b0000;
        n_vec++;
        if (dg[u] !== eg || dv[u] !== m_vld[u] ||
            di[u] !== 2'(m_own[u]) || dp[u] !== m_pre[u]) begin
          n_bad++;
          $display("FAIL model_u%0d t=%0t: gnt=%b vld=%b idx=%0d pre=%b, expected gnt=%b vld=%b idx=%0d pre=%b",
                   u, $time, dg[u], dv[u], di[u], dp[u], eg, m_vld[u], m_own[u], m_pre[u]);
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic lit(input string nm, input int u, input logic [3:0] ge,
                     input logic ve, input logic [1:0] ie, input logic pe);
    n_vec++;
    if (dg[u] !== ge || dv[u] !== ve || di[u] !== ie || dp[u] !== pe) begin
      n_bad++;
      $display("FAIL %s u%0d: gnt=%b vld=%b idx=%0d pre=%b, expected gnt=%b vld=%b idx=%0d pre=%b",
               nm, u, dg[u], dv[u], di[u], dp[u], ge, ve, ie, pe);
    end
  endtask

  logic [3:0] table_req [12] = '{4'b0000, 4'b0101, 4'b1010, 4'b1100,
                                 4'b0011, 4'b1111, 4'b1001, 4'b0110,
                                 4'b0000, 4'b1000, 4'b0111, 4'b1110};

  initial begin
    // Reset state.
    reset = 1'b1; req = 4'b0000;
    step(); chk_en = 1'b1;
    step();
    for (int u = 0; u < 3; u++) lit("reset", u, 4'b0000, 1'b0, 2'd0, 1'b0);

    // Single requester 0: one-cycle latency, drops one cycle after req.
    reset = 1'b0; req = 4'b0001;
    lit("no_comb_gnt", 0, 4'b0000, 1'b0, 2'd0, 1'b0);
    step(); lit("req0_first", 0, 4'b0001, 1'b1, 2'd0, 1'b0);
    step(); step();
    req = 4'b0000;
    step(); lit("req0_drop", 0, 4'b0000, 1'b0, 2'd0, 1'b0);

    // All requesting from a fresh reset: 0,1,2,... rotating at the hold limit.
    reset = 1'b1; step();
    reset = 1'b0; req = 4'b1111;
    for (int i = 0; i < 24; i++) begin
      step();
      lit("all_a", 0, 4'b0001 << ((i / 8) % 4), 1'b1, 2'((i / 8) % 4), (i % 8 == 0) && (i > 0));
      lit("all_b", 1, 4'b0001 << ((i / 4) % 4), 1'b1, 2'((i / 4) % 4), (i % 4 == 0) && (i > 0));
      lit("all_c", 2, 4'b0001 << (i % 4),       1'b1, 2'(i % 4),       i > 0);
    end

    // Owner 2 releases while 0 and 3 wait: search from 3, no gap, no preempt.
    req = 4'b1001;
    step(); lit("rel2_to3", 0, 4'b1000, 1'b1, 2'd3, 1'b0);

    // Lone requester 1 for 20 cycles never pre-empted.
    req = 4'b0010;
    for (int i = 0; i < 20; i++) begin
      step();
      lit("lone1_b", 1, 4'b0010, 1'b1, 2'd1, 1'b0);
    end

    // Pointer wrap 3 -> 0, then search from 1.
    req = 4'b1000; step(); lit("to3", 0, 4'b1000, 1'b1, 2'd3, 1'b0);
    req = 4'b0001; step(); lit("wrap_to0", 0, 4'b0001, 1'b1, 2'd0, 1'b0);
    req = 4'b1010; step(); lit("from0_to1", 0, 4'b0010, 1'b1, 2'd1, 1'b0);

    // Reset while owner 2 holds the grant.
    req = 4'b0100; step(); lit("to2", 0, 4'b0100, 1'b1, 2'd2, 1'b0);
    reset = 1'b1; req = 4'b0110;
    step(); lit("reset_mid", 0, 4'b0000, 1'b0, 2'd0, 1'b0);
    reset = 1'b0;
    step(); lit("post_reset", 0, 4'b0010, 1'b1, 2'd1, 1'b0);

    // Mixed patterns, model-checked only.
    for (int t = 0; t < 12; t++) begin
      req = table_req[t];
      for (int c = 0; c < 3; c++) step();
    end
    req = 4'b1111;
    for (int c = 0; c < 40; c++) step();
    req = 4'b0000;
    step(); step();

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
